// File: rtl/pipe_reg_stage.sv
// Pipeline register stage with valid/ready handshake, flush, bubble control-kill and stall counter.
// Define PIPE_REG_STAGE_SKID_EN to add a skid entry and drive in_ready from a flop.
module pipe_reg_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, consume;

  assign accept  = in_valid & in_ready & ~flush;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

`ifdef PIPE_REG_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctrl_d   = out_ctrl_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_ctrl_d   = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-output move can happen
      if (consume) begin
        out_valid_d  = 1'b1;
        out_ctrl_d   = skid_ctrl_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_ctrl_d  = in_ctrl;
        out_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
`else
  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_ctrl_d  = in_ctrl;
      out_data_d  = in_data;
    end else if (consume) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end
  end

  assign in_ready = ~out_valid_q | out_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_reg_stage.sv
// Self-checking bench for pipe_reg_stage: occupancy-queue reference model plus directed scenarios.
module tb_pipe_reg_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;
`ifdef PIPE_REG_STAGE_SKID_EN
  localparam int Cap = 2;
`else
  localparam int Cap = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_reg_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: entries held by the stage, in acceptance order.
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t          mq[$];
  logic [DW-1:0] m_last;
  int            m_cnt;
  logic          m_rdy_skid;

  function automatic logic exp_ready();
    if (Cap == 2) return m_rdy_skid;
    return (mq.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_last     = '0;
      m_cnt      = 0;
      m_rdy_skid = 1'b1;
    end else begin
      logic acc, con;
      ent_t e;
      acc = in_valid && exp_ready() && !flush;
      con = (mq.size() > 0) && out_ready;
      if (mq.size() > 0 && !out_ready && m_cnt < (1 << NW) - 1) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (con) void'(mq.pop_front());
        if (acc) begin
          e.c = in_ctrl;
          e.d = in_data;
          mq.push_back(e);
        end
      end
      if (mq.size() > 0) m_last = mq[0].d;
      m_rdy_skid = mq.size() < 2;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      logic          ev;
      logic [CW-1:0] ec;
      ev = mq.size() > 0;
      ec = ev ? mq[0].c : '0;
      chk("cyc_in_ready", DW'(in_ready), DW'(exp_ready()));
      chk("cyc_out_valid", DW'(out_valid), DW'(ev));
      chk("cyc_out_ctrl", DW'(out_ctrl), DW'(ec));
      chk("cyc_out_data", out_data, ev ? mq[0].d : m_last);
      chk("cyc_stall_cnt", DW'(stall_cnt), DW'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1'b1; in_data = d; in_ctrl = c;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", DW'(out_valid), 0);
    chk("rst_out_ctrl", DW'(out_ctrl), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", DW'(stall_cnt), 0);
    chk("rst_in_ready", DW'(in_ready), 1);

    // Streaming with out_ready held high
    out_ready = 1'b1;
    send(32'h11, 8'h05); tick();
    chk("stream_v0", DW'(out_valid), 1); chk("stream_d0", out_data, 32'h11);
    chk("stream_c0", DW'(out_ctrl), 32'h05);
    send(32'h22, 8'h05); tick();
    chk("stream_v1", DW'(out_valid), 1); chk("stream_d1", out_data, 32'h22);
    send(32'h33, 8'h05); tick();
    chk("stream_v2", DW'(out_valid), 1); chk("stream_d2", out_data, 32'h33);
    in_valid = 1'b0; tick();
    chk("bubble_valid", DW'(out_valid), 0); chk("bubble_ctrl", DW'(out_ctrl), 0);
    chk("bubble_data_hold", out_data, 32'h33);

    // Stall with 0xAA held; skid build takes 0xBB behind it
    do_reset();
    send(32'hAA, 8'h01); tick();
    send(32'hBB, 8'h02);
    repeat (4) tick();
    chk("stall_data", out_data, 32'hAA);
    chk("stall_cnt4", DW'(stall_cnt), 4);
    chk("stall_in_ready", DW'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("stall_rel_valid", DW'(out_valid), DW'(Cap == 2));
    if (Cap == 2) chk("stall_skid_data", out_data, 32'hBB);
    tick();
    chk("stall_drained", DW'(out_valid), 0);
    chk("stall_cnt_kept", DW'(stall_cnt), 4);

    // Flush with a same-cycle input that must be dropped
    do_reset();
    send(32'hCC, 8'hFF); tick();
    flush = 1'b1; out_ready = 1'b1; send(32'hDD, 8'h12); tick();
    chk("flush_valid", DW'(out_valid), 0); chk("flush_ctrl", DW'(out_ctrl), 0);
    chk("flush_data", out_data, 32'hCC);
    flush = 1'b0; in_valid = 1'b0; tick();
    chk("flush_no_dd", DW'(out_valid), 0); chk("flush_data2", out_data, 32'hCC);

    // Saturation then asynchronous reset mid-cycle
    do_reset();
    send(32'h5A, 8'h3C); tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_cnt", DW'(stall_cnt), 15);
    chk("sat_valid", DW'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", DW'(out_valid), 0); chk("arst_ctrl", DW'(out_ctrl), 0);
    chk("arst_data", out_data, 0); chk("arst_cnt", DW'(stall_cnt), 0);
    tick();
    rst = 1'b0;
    #1 chk("arst_in_ready", DW'(in_ready), 1);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 99) < 65);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 4);
      in_data   = $urandom;
      in_ctrl   = CW'($urandom);
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_stage.md
# pipe_reg_stage

Parametrised pipeline register stage with a valid/ready handshake, flush, bubble control-kill and a saturating stall counter. It is the generic successor of the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB): each core stage boundary instantiates one, sized for its payload. Control bits (regwrite, memwrite byte enables, memtoreg, ...) travel in a separate field that is forced to zero whenever the stage holds a bubble.

## Interface
- DATA_W, 32: width of the data payload (ALU result, store data, immediate, PC+4, instruction word, concatenated by the instantiator).
- CTRL_W, 8: width of the control payload, zeroed on bubbles.
- CNT_W, 16: width of the stall counter.

- clk  in  1  stage clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  squash; the stage content is discarded at the next edge.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_ctrl  in  CTRL_W  control payload.
- in_data  in  DATA_W  data payload.
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0.
- out_data  out  DATA_W  registered data; holds its last value on bubbles.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Accept = in_valid & in_ready & ~flush. Consume = out_valid & out_ready.
- A transfer occurs only on accept; the payload is never modified in flight.
- Flush dominates: at the next edge every stored entry is dropped, out_valid=0 and out_ctrl=0. An input offered in the same cycle is not taken. out_data is not cleared.
- Bubble rule: whenever the output register becomes empty (consume without accept, or flush), out_ctrl is written 0 in the same edge.
- Accept and consume in the same cycle: the new entry replaces the old one, out_valid stays 1, and there is no bubble.
- stall_cnt increments each cycle with out_valid & ~out_ready, saturates at 2^CNT_W-1, and is cleared only by rst, not by flush.
- Entries are delivered in acceptance order, with no loss or duplication.

## Timing
- Reset values (asserted immediately, asynchronously): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1 once rst is low. Handshakes while rst=1 are ignored.
- Latency: 1 cycle from accept to out_valid=1 with the same payload.
- Throughput: 1 entry/cycle when out_ready is held at 1.
- If rst is asserted mid-stall, stored entries are lost and the counter is zeroed.

## Configuration
- PIPE_REG_STAGE_SKID_EN not defined:
  - single entry;
  - in_ready = ~out_valid | out_ready, combinational from out_ready.
- PIPE_REG_STAGE_SKID_EN defined:
  - second, skid entry is added and in_ready comes straight from a flop (in_ready = skid empty), which breaks the ready path;
  - an entry accepted while the output is stalled goes to the skid entry, and on the next consume it moves to the output register;
  - a third entry cannot be accepted while both entries are full;
  - flush clears both entries;
  - latency stays 1 cycle when not stalled.

## Test plan
- Streaming: out_ready=1, send data 0x11,0x22,0x33 back-to-back with ctrl 0x05. Required: out_valid=1 for three consecutive cycles, out_data 0x11,0x22,0x33, each one cycle after its input.
- Stall: hold out_ready=0 for 4 cycles with 0xAA held in the stage. Required: out_data stays 0xAA and stall_cnt=4.
  - Without skid: in_ready=0.
  - With skid: exactly one more entry (0xBB) is accepted and delivered after 0xAA.
- Flush: set flush=1 while the stage holds 0xCC with ctrl 0xFF. Required: at the next edge out_valid=0, out_ctrl=0x00, out_data=0xCC, and a same-cycle input 0xDD is never delivered.
- Bubble: a single entry is consumed with no new input. Required: out_valid=0, out_ctrl=0 on the next cycle.
- Saturation and reset: CNT_W=4, stall for 20 cycles. Required: stall_cnt=15.
  - Then assert rst mid-cycle. Required: all outputs return to their reset values immediately, before the next edge.
